sram_mbist_march_ctrl: RTL

- Parametrised March C- memory-BIST engine that drives the BIST port of a single-port SRAM macro with byte/bit mask: BIST_EN, MEN, WEN, REN, ADDR, DIN, BM.
- Checks read data with a configurable read latency and reports pass/fail, the first failing address, an accumulated failing-bit mask and a saturating fail count.
- One instance sits next to each SRAM macro; a test controller or a JTAG/DFT register starts it and reads its results.

---
 rtl/sram_mbist_march_ctrl.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/sram_mbist_march_ctrl.sv
// March C- memory-BIST engine for one single-port SRAM macro with bit mask.
// Drives registered BIST-port controls and checks read data READ_LAT cycles after each read.
module sram_mbist_march_ctrl #(
  parameter int unsigned       DATA_W   = 8,
  parameter int unsigned       ADDR_W   = 9,
  parameter int unsigned       DEPTH    = 512,
  parameter int unsigned       READ_LAT = 1,
  parameter logic [DATA_W-1:0] BG       = '0,
  parameter int unsigned       CNT_W    = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              abort_i,
  output logic              bist_en_o,
  output logic              bist_men_o,
  output logic              bist_wen_o,
  output logic              bist_ren_o,
  output logic [ADDR_W-1:0] bist_addr_o,
  output logic [DATA_W-1:0] bist_din_o,
  output logic [DATA_W-1:0] bist_bm_o,
  input  logic [DATA_W-1:0] bist_dout_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [ADDR_W-1:0] fail_addr_o,
  output logic [DATA_W-1:0] fail_mask_o,
  output logic [CNT_W-1:0]  fail_cnt_o,
  output logic [2:0]        element_o
);

  // state   | meaning
  // IDLE    | waiting for start; results of an aborted run are held
  // M0..M5  | March C- elements, one SRAM op per cycle
  // DRAIN   | last reads still travelling through the compare pipeline
  // DONE    | results valid until the next start
  typedef enum logic [3:0] {
    S_IDLE, S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_DRAIN, S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

  function automatic logic elem_up(input state_t s);
    return !(s == S_M3 || s == S_M4);
  endfunction

  function automatic logic elem_two_op(input state_t s);
    return (s == S_M1 || s == S_M2 || s == S_M3 || s == S_M4);
  endfunction

  function automatic logic [DATA_W-1:0] rd_pat(input state_t s);
    return (s == S_M2 || s == S_M4) ? ~BG : BG;
  endfunction

  function automatic logic [DATA_W-1:0] wr_pat(input state_t s);
    return (s == S_M1 || s == S_M3) ? ~BG : BG;
  endfunction

  function automatic state_t next_elem(input state_t s);
    case (s)
      S_M0:    return S_M1;
      S_M1:    return S_M2;
      S_M2:    return S_M3;
      S_M3:    return S_M4;
      S_M4:    return S_M5;
      default: return S_DRAIN;
    endcase
  endfunction

  state_t              state_q, state_n;
  logic                phase_q, phase_n;
  logic [1:0]          drain_q, drain_n;
  logic [ADDR_W-1:0]   addr_n;
  logic [DATA_W-1:0]   exp_q;
  logic                busy, flush, start_acc, last_addr;
  logic                op_men, op_wen, op_ren;

  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign flush     = abort_i && busy;
  assign start_acc = start_i && !busy;
  assign last_addr = elem_up(state_q) ? (bist_addr_o == ADDR_LAST) : (bist_addr_o == '0);

  always_comb begin
    state_n = state_q;
    addr_n  = bist_addr_o;
    phase_n = phase_q;
    drain_n = drain_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_n = S_M0;
          addr_n  = '0;
          phase_n = 1'b0;
        end
      end
      S_DRAIN: begin
        if (drain_q == 2'd0) state_n = S_DONE;
        else                 drain_n = drain_q - 2'd1;
      end
      default: begin
        if (elem_two_op(state_q) && !phase_q) begin
          phase_n = 1'b1;
        end else begin
          phase_n = 1'b0;
          if (last_addr) begin
            state_n = next_elem(state_q);
            // DRAIN counts as "up" so the address parks at 0 once the march ends
            addr_n  = elem_up(state_n) ? '0 : ADDR_LAST;
            drain_n = 2'(READ_LAT - 1);
          end else if (elem_up(state_q)) begin
            addr_n = bist_addr_o + ADDR_W'(1);
          end else begin
            addr_n = bist_addr_o - ADDR_W'(1);
          end
        end
      end
    endcase
    if (flush) begin
      state_n = S_IDLE;
      addr_n  = '0;
      phase_n = 1'b0;
      drain_n = 2'd0;
    end
  end

  assign op_men = (state_n inside {[S_M0:S_M5]});
  assign op_wen = op_men && (state_n == S_M0 || phase_n);
  assign op_ren = op_men && !op_wen;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      phase_q     <= 1'b0;
      drain_q     <= 2'd0;
      bist_en_o   <= 1'b0;
      bist_men_o  <= 1'b0;
      bist_wen_o  <= 1'b0;
      bist_ren_o  <= 1'b0;
      bist_addr_o <= '0;
      bist_din_o  <= '0;
      bist_bm_o   <= '0;
      exp_q       <= '0;
    end else begin
      state_q     <= state_n;
      phase_q     <= phase_n;
      drain_q     <= drain_n;
      bist_en_o   <= (state_n inside {[S_M0:S_DRAIN]});
      bist_men_o  <= op_men;
      bist_wen_o  <= op_wen;
      bist_ren_o  <= op_ren;
      bist_addr_o <= addr_n;
      bist_din_o  <= op_wen ? wr_pat(state_n) : '0;
      bist_bm_o   <= op_wen ? '1 : '0;
      exp_q       <= op_ren ? rd_pat(state_n) : '0;
    end
  end

  // Compare pipeline: stage 0 captures the read cycle currently on the port
  logic [READ_LAT-1:0]             pv_q;
  logic [READ_LAT-1:0][ADDR_W-1:0] pa_q;
  logic [READ_LAT-1:0][DATA_W-1:0] pe_q;
  logic                            cmp_v;
  logic [DATA_W-1:0]               mism;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush) begin
      pv_q <= '0;
      pa_q <= '0;
      pe_q <= '0;
    end else begin
      pv_q[0] <= bist_ren_o;
      pa_q[0] <= bist_addr_o;
      pe_q[0] <= exp_q;
      for (int i = 1; i < READ_LAT; i++) begin
        pv_q[i] <= pv_q[i-1];
        pa_q[i] <= pa_q[i-1];
        pe_q[i] <= pe_q[i-1];
      end
    end
  end

  assign cmp_v = pv_q[READ_LAT-1] && !flush;
  assign mism  = bist_dout_i ^ pe_q[READ_LAT-1];

  always_ff @(posedge clk_i) begin
    if (!rst_ni || start_acc) begin
      fail_addr_o <= '0;
      fail_mask_o <= '0;
      fail_cnt_o  <= '0;
    end else if (cmp_v && (mism != '0)) begin
      fail_mask_o <= fail_mask_o | mism;
      if (fail_cnt_o == '0) fail_addr_o <= pa_q[READ_LAT-1];
      if (fail_cnt_o != '1) fail_cnt_o  <= fail_cnt_o + CNT_W'(1);
    end
  end

  assign busy_o = busy;
  assign done_o = (state_q == S_DONE);
  assign pass_o = done_o && (fail_cnt_o == '0);

  always_comb begin
    element_o = 3'd7;
    case (state_q)
      S_M0:    element_o = 3'd0;
      S_M1:    element_o = 3'd1;
      S_M2:    element_o = 3'd2;
      S_M3:    element_o = 3'd3;
      S_M4:    element_o = 3'd4;
      S_M5:    element_o = 3'd5;
      S_DRAIN: element_o = 3'd6;
      default: element_o = 3'd7;
    endcase
  end

endmodule
